operand_loader_16: RTL and testbench

- Byte-serial front end for the 16-bit ALU operand cache registers.
- Accepts bytes over a valid/ready handshake and assembles them into two 16-bit operands, A then B, each low byte first.
- Drives a shared 16-bit data bus plus one-cycle store strobes, which feed the storage-activator inputs of the operand-A and operand-B cache registers.
- Signals the ALU sequencer once both operands are committed.

---
 rtl/operand_loader_16_if.sv | 43 ++++
 rtl/operand_loader_16.sv | 132 +++++++++++++
 tb/tb_operand_loader_16.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_16_if.sv
// Byte-stream handshake and operand-cache bus of the 16-bit operand loader.
// The slave side is the loader; the master side is whatever feeds it bytes
// and observes the store strobes.
interface operand_loader_16_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               flush;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic [15:0]        data_out;
    logic               store_a;
    logic               store_b;
    logic               operands_ready;
    logic               busy;
    logic [COUNT_W-1:0] pair_count;

    modport master (
        output flush,
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  data_out,
        input  store_a,
        input  store_b,
        input  operands_ready,
        input  busy,
        input  pair_count
    );

    modport slave (
        input  flush,
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output data_out,
        output store_a,
        output store_b,
        output operands_ready,
        output busy,
        output pair_count
    );
endinterface

// File: rtl/operand_loader_16.sv
// Byte-serial front end for the ALU operand cache registers. Assembles two
// 16-bit operands (A then B) from a byte stream, drives them on a shared bus
// with one-cycle store strobes and pulses operands_ready once per pair.
module operand_loader_16 #(
    parameter bit          HI_FIRST = 1'b0,
    parameter int unsigned COUNT_W  = 8
) (
    input logic                 CLK,
    input logic                 RST_N,
    operand_loader_16_if.slave  bus
);

    typedef enum logic [2:0] {
        StAFirst,
        StASecond,
        StBFirst,
        StBSecond,
        StCommit,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic [15:0]        data_q, data_d;
    logic               store_a_q, store_a_d;
    logic               store_b_q, store_b_d;
    logic               rdy_q, rdy_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               byte_ready;
    logic               xfer;
    logic [15:0]        word;

    // Ready only in byte-accepting states, never during flush or reset.
    always_comb begin
        byte_ready = 1'b0;
        if (RST_N && !bus.flush) begin
            byte_ready = (state_q == StAFirst) || (state_q == StASecond) ||
                         (state_q == StBFirst) || (state_q == StBSecond);
        end
    end

    assign xfer = bus.byte_valid && byte_ready;
    assign word = HI_FIRST ? {hold_q, bus.byte_in} : {bus.byte_in, hold_q};

    // Next-state and registered-output logic of the byte sequencer.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data_d    = data_q;
        store_a_d = 1'b0;
        store_b_d = 1'b0;
        rdy_d     = 1'b0;
        count_d   = count_q;

        if (bus.flush) begin
            // Abort the partial pair; strobes already out finish on their own.
            state_d = StAFirst;
            hold_d  = 8'h00;
        end else begin
            unique case (state_q)
                StAFirst: begin
                    if (xfer) begin
                        hold_d  = bus.byte_in;
                        state_d = StASecond;
                    end
                end
                StASecond: begin
                    if (xfer) begin
                        data_d    = word;
                        store_a_d = 1'b1;
                        state_d   = StBFirst;
                    end
                end
                StBFirst: begin
                    if (xfer) begin
                        hold_d  = bus.byte_in;
                        state_d = StBSecond;
                    end
                end
                StBSecond: begin
                    if (xfer) begin
                        data_d    = word;
                        store_b_d = 1'b1;
                        state_d   = StCommit;
                    end
                end
                StCommit: begin
                    rdy_d   = 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StAFirst;
                end
                default: begin
                    state_d = StAFirst;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StAFirst;
            hold_q    <= 8'h00;
            data_q    <= 16'h0000;
            store_a_q <= 1'b0;
            store_b_q <= 1'b0;
            rdy_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            store_a_q <= store_a_d;
            store_b_q <= store_b_d;
            rdy_q     <= rdy_d;
            count_q   <= count_d;
        end
    end

    assign bus.byte_ready     = byte_ready;
    assign bus.data_out       = data_q;
    assign bus.store_a        = store_a_q;
    assign bus.store_b        = store_b_q;
    assign bus.operands_ready = rdy_q;
    assign bus.busy           = (state_q != StAFirst);
    assign bus.pair_count     = count_q;

endmodule

// File: tb/tb_operand_loader_16.sv
// Directed bench for operand_loader_16: one instance per byte order, driven
// by the same byte stream.
module tb_operand_loader_16;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       flush_r;
    logic [7:0] byte_r;
    logic       valid_r;

    always #5 CLK = ~CLK;

    operand_loader_16_if #(.COUNT_W(8)) bus0 ();
    operand_loader_16_if #(.COUNT_W(8)) bus1 ();

    assign bus0.flush      = flush_r;
    assign bus0.byte_in    = byte_r;
    assign bus0.byte_valid = valid_r;
    assign bus1.flush      = flush_r;
    assign bus1.byte_in    = byte_r;
    assign bus1.byte_valid = valid_r;

    operand_loader_16 #(.HI_FIRST(1'b0), .COUNT_W(8)) dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0)
    );

    operand_loader_16 #(.HI_FIRST(1'b1), .COUNT_W(8)) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1)
    );

    // Strobe capture and protocol monitor, sampled on the falling edge.
    logic [15:0] qa0[$], qb0[$], qa1[$], qb1[$];
    logic [7:0]  qr0[$], qr1[$];
    int          viol = 0;
    logic        pa0 = 1'b0, pb0 = 1'b0, pr0 = 1'b0;
    logic        pa1 = 1'b0, pb1 = 1'b0, pr1 = 1'b0;

    always @(negedge CLK) begin
        if (bus0.store_a) qa0.push_back(bus0.data_out);
        if (bus0.store_b) qb0.push_back(bus0.data_out);
        if (bus0.operands_ready) qr0.push_back(bus0.pair_count);
        if (bus1.store_a) qa1.push_back(bus1.data_out);
        if (bus1.store_b) qb1.push_back(bus1.data_out);
        if (bus1.operands_ready) qr1.push_back(bus1.pair_count);
        // Pulses exactly one cycle wide.
        if ((bus0.store_a && pa0) || (bus0.store_b && pb0) || (bus0.operands_ready && pr0)) viol++;
        if ((bus1.store_a && pa1) || (bus1.store_b && pb1) || (bus1.operands_ready && pr1)) viol++;
        // operands_ready must follow store_b by exactly one cycle.
        if ((bus0.operands_ready && !pb0) || (bus1.operands_ready && !pb1)) viol++;
        // No byte acceptance during COMMIT / DONE.
        if ((bus0.store_b || bus0.operands_ready) && bus0.byte_ready) viol++;
        if ((bus1.store_b || bus1.operands_ready) && bus1.byte_ready) viol++;
        pa0 <= bus0.store_a;
        pb0 <= bus0.store_b;
        pr0 <= bus0.operands_ready;
        pa1 <= bus1.store_a;
        pb1 <= bus1.store_b;
        pr1 <= bus1.operands_ready;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic clear_q();
        qa0.delete(); qb0.delete(); qr0.delete();
        qa1.delete(); qb1.delete(); qr1.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge CLK);
        byte_r  = b;
        valid_r = 1'b1;
        n = 0;
        while (!bus0.byte_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!bus0.byte_ready) begin
            n_total++;
            $display("FAIL send_byte: byte_ready stuck at 0 for byte %0h", b);
        end
        @(posedge CLK);
        #1;
        valid_r = 1'b0;
        repeat (gap) @(posedge CLK);
    endtask

    task automatic wait_pair();
        int n;
        n = 0;
        while (qr0.size() == 0 && n < 12) begin
            @(posedge CLK);
            n++;
        end
        if (qr0.size() == 0) begin
            n_total++;
            $display("FAIL wait_pair: no operands_ready within %0d cycles", n);
        end
    endtask

    task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
        wait_pair();
    endtask

    task automatic check_pair(input string name, input logic [15:0] a0, input logic [15:0] b0,
                              input logic [15:0] a1, input logic [15:0] b1,
                              input logic [7:0] pc);
        chk({name, " lo store_a count"}, qa0.size(), 1);
        if (qa0.size() > 0) chk({name, " lo A"}, qa0[0], a0);
        chk({name, " lo store_b count"}, qb0.size(), 1);
        if (qb0.size() > 0) chk({name, " lo B"}, qb0[0], b0);
        chk({name, " lo ready count"}, qr0.size(), 1);
        if (qr0.size() > 0) chk({name, " lo pair_count"}, qr0[0], pc);
        chk({name, " hi store_a count"}, qa1.size(), 1);
        if (qa1.size() > 0) chk({name, " hi A"}, qa1[0], a1);
        chk({name, " hi store_b count"}, qb1.size(), 1);
        if (qb1.size() > 0) chk({name, " hi B"}, qb1[0], b1);
        chk({name, " hi ready count"}, qr1.size(), 1);
        if (qr1.size() > 0) chk({name, " hi pair_count"}, qr1[0], pc);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        flush_r = 1'b0;
        valid_r = 1'b0;
        RST_N   = 1'b0;
        @(negedge CLK);
        RST_N   = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          gap;
        logic [15:0] lo_a, lo_b, hi_a, hi_b;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int pc_exp;
        vecs[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 0, 16'h1234, 16'h5678, 16'h3412, 16'h7856};
        vecs[1] = '{8'h34, 8'h12, 8'h78, 8'h56, 3, 16'h1234, 16'h5678, 16'h3412, 16'h7856};
        vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 1, 16'h0201, 16'h0403, 16'h0102, 16'h0304};
        vecs[3] = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 0, 16'h00FF, 16'h5AA5, 16'hFF00, 16'hA55A};

        RST_N   = 1'b0;
        flush_r = 1'b0;
        valid_r = 1'b0;
        byte_r  = 8'h00;
        repeat (2) @(negedge CLK);
        chk("reset data_out", bus0.data_out, 16'h0000);
        chk("reset store_a", bus0.store_a, 1'b0);
        chk("reset store_b", bus0.store_b, 1'b0);
        chk("reset operands_ready", bus0.operands_ready, 1'b0);
        chk("reset pair_count", bus0.pair_count, 8'h00);
        chk("reset byte_ready", bus0.byte_ready, 1'b0);
        chk("reset busy", bus0.busy, 1'b0);
        RST_N = 1'b1;
        #1;
        chk("post-reset byte_ready", bus0.byte_ready, 1'b1);

        // Table-driven pairs; pair_count accumulates across them.
        pc_exp = 0;
        for (int i = 0; i < 4; i++) begin
            clear_q();
            pc_exp++;
            send_pair(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].gap);
            check_pair($sformatf("vec%0d", i), vecs[i].lo_a, vecs[i].lo_b,
                       vecs[i].hi_a, vecs[i].hi_b, 8'(pc_exp));
        end

        // Flush after the third byte: only A was stored, no ready pulse.
        do_reset();
        clear_q();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        @(negedge CLK);
        flush_r = 1'b1;
        #1;
        chk("flush byte_ready", bus0.byte_ready, 1'b0);
        @(posedge CLK);
        #1;
        flush_r = 1'b0;
        repeat (3) @(posedge CLK);
        chk("flush lo A count", qa0.size(), 1);
        if (qa0.size() > 0) chk("flush lo A", qa0[0], 16'hBBAA);
        chk("flush hi A count", qa1.size(), 1);
        if (qa1.size() > 0) chk("flush hi A", qa1[0], 16'hAABB);
        chk("flush store_b count", qb0.size(), 0);
        chk("flush ready count", qr0.size(), 0);
        chk("flush pair_count", bus0.pair_count, 8'h00);
        chk("flush busy", bus0.busy, 1'b0);
        clear_q();
        send_pair(8'h01, 8'h02, 8'h03, 8'h04, 0);
        check_pair("after-flush", 16'h0201, 16'h0403, 16'h0102, 16'h0304, 8'h01);

        // Flush during COMMIT: store_b completes, DONE and the count are suppressed.
        clear_q();
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        send_byte(8'h07, 0);
        send_byte(8'h08, 0);
        @(negedge CLK);
        chk("commit-flush store_b high", bus0.store_b, 1'b1);
        flush_r = 1'b1;
        @(posedge CLK);
        #1;
        flush_r = 1'b0;
        repeat (3) @(posedge CLK);
        chk("commit-flush store_b count", qb0.size(), 1);
        if (qb0.size() > 0) chk("commit-flush B", qb0[0], 16'h0807);
        chk("commit-flush ready count", qr0.size(), 0);
        chk("commit-flush pair_count", bus0.pair_count, 8'h01);
        chk("commit-flush hi pair_count", bus1.pair_count, 8'h01);

        // pair_count wraps after 256 pairs.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            clear_q();
            send_pair(8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 0);
            if (i == 254) chk("wrap pc 255", bus0.pair_count, 8'hFF);
            if (i == 255) begin
                chk("wrap ready pc 0", (qr0.size() > 0) ? qr0[0] : 8'hEE, 8'h00);
                chk("wrap pc 0", bus0.pair_count, 8'h00);
            end
            if (i == 256) chk("wrap pc 1", bus1.pair_count, 8'h01);
        end

        // Asynchronous reset between the 2nd and 3rd bytes.
        clear_q();
        send_byte(8'h99, 0);
        send_byte(8'h88, 0);
        chk("mid-pair busy", bus0.busy, 1'b1);
        chk("mid-pair store_a", bus0.store_a, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async data_out", bus0.data_out, 16'h0000);
        chk("async store_a", bus0.store_a, 1'b0);
        chk("async byte_ready", bus0.byte_ready, 1'b0);
        chk("async busy", bus0.busy, 1'b0);
        chk("async pair_count", bus0.pair_count, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        clear_q();
        send_pair(8'h11, 8'h22, 8'h33, 8'h44, 0);
        check_pair("post-async", 16'h2211, 16'h4433, 16'h1122, 16'h3344, 8'h01);

        repeat (2) @(posedge CLK);
        chk("protocol violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
